// File: rtl/cache_pkg.sv
// Shared definitions for the cache replacement controller:
// policy encodings and the victim-select LFSR.
package cache_pkg;

    typedef enum logic [1:0] {
        POL_LRU  = 2'b00,
        POL_FIFO = 2'b01,
        POL_RAND = 2'b10,
        POL_RSVD = 2'b11
    } policy_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;

    // Taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(
        input logic [7:0] s
    );
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/replace_age_update.sv
// One set's age permutation: touch a way (ages below it shift up,
// touched way becomes youngest) and report the oldest way.
module replace_age_update
    import cache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int WW   = $clog2(WAYS)
) (
    input  logic [WAYS*WW-1:0] age_i,
    input  logic [WW-1:0]      touch_i,
    output logic [WAYS*WW-1:0] age_o,
    output logic [WW-1:0]      oldest_o
);

    logic [WW-1:0] ref_age;
    logic [WW-1:0] cur;

    always_comb begin
        ref_age = age_i[touch_i*WW +: WW];
        cur     = '0;
        age_o   = age_i;
        for (int w = 0; w < WAYS; w++) begin
            cur = age_i[w*WW +: WW];
            if (WW'(w) == touch_i) begin
                age_o[w*WW +: WW] = '0;
            end else if (cur < ref_age) begin
                age_o[w*WW +: WW] = cur + WW'(1);
            end else begin
                age_o[w*WW +: WW] = cur;
            end
        end
    end

    // Kept separate from the update so the victim path has no
    // false loop through touch_i.
    always_comb begin
        oldest_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_i[w*WW +: WW] == WW'(WAYS - 1)) begin
                oldest_o = WW'(w);
            end
        end
    end

endmodule

// File: rtl/cache_replace_ctrl.sv
// N-way, multi-set hit/fill/victim way selector with per-set
// true-LRU age permutations and run-time LRU/FIFO/random policy.
module cache_replace_ctrl
    import cache_pkg::*;
#(
    parameter  int WAYS = 4,
    parameter  int SETS = 8,
    localparam int WW   = $clog2(WAYS),
    localparam int SW   = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic            CLK,
    input  logic            ResetN,
    input  logic            Access,
    input  logic [SW-1:0]   SetIdx,
    input  logic [WAYS-1:0] Valid,
    input  logic [WAYS-1:0] Eq,
    input  logic [1:0]      Policy,
    input  logic            Flush,
    output logic [WW-1:0]   Way,
    output logic            Hit,
    output logic            Evict,
    output logic            MultiHit,
    output logic            Done
);

    function automatic logic [WAYS*WW-1:0] reset_perm();
        logic [WAYS*WW-1:0] r;
        r = '0;
        for (int w = 0; w < WAYS; w++) begin
            r[w*WW +: WW] = WW'(w);
        end
        return r;
    endfunction

    localparam logic [WAYS*WW-1:0] RESET_PERM = reset_perm();

    policy_e            pol;
    logic [SW-1:0]      set_sel;
    logic [WAYS-1:0]    eq_m;
    logic               hit_c;
    logic               multi_c;
    logic               all_valid;
    logic               accept;
    logic               do_touch;
    logic [WW-1:0]      hit_way;
    logic [WW-1:0]      inv_way;
    logic [WW-1:0]      oldest;
    logic [WW-1:0]      victim;
    logic [WW-1:0]      sel_way;
    logic [WAYS*WW-1:0] cur_age;
    logic [WAYS*WW-1:0] nxt_age;

    logic [WAYS*WW-1:0] age_q [SETS];
    logic [WAYS*WW-1:0] age_d [SETS];
    logic [7:0]         lfsr_q, lfsr_d;
    logic [WW-1:0]      way_q, way_d;
    logic               hit_q, hit_d;
    logic               evict_q, evict_d;
    logic               multi_q, multi_d;
    logic               done_q, done_d;

    assign pol       = policy_e'(Policy);
    assign set_sel   = (SETS > 1) ? SetIdx : '0;
    assign accept    = Access && !Flush;
    assign eq_m      = Eq & Valid;
    assign hit_c     = |eq_m;
    assign multi_c   = (eq_m & (eq_m - WAYS'(1))) != '0;
    assign all_valid = &Valid;
    assign cur_age   = age_q[set_sel];

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (eq_m[w]) begin
                hit_way = WW'(w);
            end
            if (!Valid[w]) begin
                inv_way = WW'(w);
            end
        end
    end

    always_comb begin
        victim = oldest;
        if (pol == POL_RAND) begin
            victim = lfsr_q[WW-1:0];
        end
    end

    always_comb begin
        sel_way = victim;
        if (hit_c) begin
            sel_way = hit_way;
        end else if (!all_valid) begin
            sel_way = inv_way;
        end
    end

    // FIFO ages track insertion order only, so hits never reorder.
    assign do_touch = (pol != POL_FIFO) || !hit_c;

    replace_age_update #(
        .WAYS (WAYS),
        .WW   (WW)
    ) u_age (
        .age_i    (cur_age),
        .touch_i  (sel_way),
        .age_o    (nxt_age),
        .oldest_o (oldest)
    );

    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            age_d[s] = Flush ? RESET_PERM : age_q[s];
        end
        if (accept && do_touch) begin
            age_d[set_sel] = nxt_age;
        end
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        way_d   = way_q;
        hit_d   = hit_q;
        evict_d = evict_q;
        multi_d = multi_q;
        done_d  = accept;
        if (accept) begin
            lfsr_d  = lfsr_step(lfsr_q);
            way_d   = sel_way;
            hit_d   = hit_c;
            evict_d = !hit_c && all_valid;
            multi_d = multi_c;
        end
    end

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            for (int s = 0; s < SETS; s++) begin
                age_q[s] <= RESET_PERM;
            end
            lfsr_q  <= LFSR_SEED;
            way_q   <= '0;
            hit_q   <= 1'b0;
            evict_q <= 1'b0;
            multi_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int s = 0; s < SETS; s++) begin
                age_q[s] <= age_d[s];
            end
            lfsr_q  <= lfsr_d;
            way_q   <= way_d;
            hit_q   <= hit_d;
            evict_q <= evict_d;
            multi_q <= multi_d;
            done_q  <= done_d;
        end
    end

    assign Way      = way_q;
    assign Hit      = hit_q;
    assign Evict    = evict_q;
    assign MultiHit = multi_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Directed self-checking bench for cache_replace_ctrl
// (WAYS=4, SETS=8); ages packed as {w3,w2,w1,w0}.
module tb_cache_replace_ctrl;

    logic       CLK;
    logic       ResetN;
    logic       Access;
    logic [2:0] SetIdx;
    logic [3:0] Valid;
    logic [3:0] Eq;
    logic [1:0] Policy;
    logic       Flush;
    logic [1:0] Way;
    logic       Hit;
    logic       Evict;
    logic       MultiHit;
    logic       Done;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] LRU  = 2'b00;
    localparam logic [1:0] FIFO = 2'b01;
    localparam logic [1:0] RND  = 2'b10;

    cache_replace_ctrl dut (
        .CLK      (CLK),
        .ResetN   (ResetN),
        .Access   (Access),
        .SetIdx   (SetIdx),
        .Valid    (Valid),
        .Eq       (Eq),
        .Policy   (Policy),
        .Flush    (Flush),
        .Way      (Way),
        .Hit      (Hit),
        .Evict    (Evict),
        .MultiHit (MultiHit),
        .Done     (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic do_reset();
        @(negedge CLK);
        ResetN = 1'b0;
        Access = 1'b0;
        Flush  = 1'b0;
        #3;
        @(negedge CLK);
        ResetN = 1'b1;
    endtask

    task automatic do_access(input logic [2:0] s, input logic [3:0] v,
                             input logic [3:0] e, input logic [1:0] p);
        @(negedge CLK);
        SetIdx = s;
        Valid  = v;
        Eq     = e;
        Policy = p;
        Access = 1'b1;
        @(posedge CLK);
        #1;
        Access = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] a;
        do_reset();
        checks++;
        if (Way !== 2'd0) begin
            errors++; $display("FAIL reset_way got %0d exp 0", Way);
        end
        checks++;
        if ({Hit, Evict, MultiHit, Done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000",
                     {Hit, Evict, MultiHit, Done});
        end
        a = dut.age_q[0];
        checks++;
        if (a !== 8'hE4) begin
            errors++; $display("FAIL reset_age0 got %h exp e4", a);
        end
        a = dut.age_q[7];
        checks++;
        if (a !== 8'hE4) begin
            errors++; $display("FAIL reset_age7 got %h exp e4", a);
        end
    endtask

    task automatic test_first_fill();
        logic [7:0] a;
        do_reset();
        do_access(3'd3, 4'b0000, 4'b0000, LRU);
        checks++;
        if ({Way, Hit, Evict, Done} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fill0 got way=%0d h=%b e=%b d=%b exp 0 0 0 1",
                     Way, Hit, Evict, Done);
        end
        do_access(3'd3, 4'b0001, 4'b0000, LRU);
        checks++;
        if (Way !== 2'd1) begin
            errors++; $display("FAIL fill1_way got %0d exp 1", Way);
        end
        a = dut.age_q[3];
        checks++;
        if (a !== 8'hE1) begin
            errors++; $display("FAIL fill1_age got %h exp e1", a);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({Done, Way} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL done_pulse got d=%b way=%0d exp d=0 way=1",
                     Done, Way);
        end
    endtask

    task automatic fill_set0(input logic [1:0] p);
        do_access(3'd0, 4'b0000, 4'b0000, p);
        do_access(3'd0, 4'b0001, 4'b0000, p);
        do_access(3'd0, 4'b0011, 4'b0000, p);
        do_access(3'd0, 4'b0111, 4'b0000, p);
    endtask

    task automatic test_lru();
        do_reset();
        fill_set0(LRU);
        checks++;
        if (Way !== 2'd3) begin
            errors++; $display("FAIL lru_fill3 got %0d exp 3", Way);
        end
        do_access(3'd0, 4'b1111, 4'b0001, LRU);
        checks++;
        if ({Hit, Way, Evict} !== {1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL lru_hit got h=%b way=%0d e=%b exp 1 0 0",
                     Hit, Way, Evict);
        end
        do_access(3'd0, 4'b1111, 4'b0000, LRU);
        checks++;
        if ({Hit, Way, Evict} !== {1'b0, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL lru_victim1 got h=%b way=%0d e=%b exp 0 1 1",
                     Hit, Way, Evict);
        end
        do_access(3'd0, 4'b1111, 4'b0000, LRU);
        checks++;
        if ({Way, Evict} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL lru_victim2 got way=%0d e=%b exp 2 1", Way, Evict);
        end
    endtask

    task automatic test_fifo();
        logic [7:0] a;
        do_reset();
        fill_set0(FIFO);
        do_access(3'd0, 4'b1111, 4'b0001, FIFO);
        checks++;
        if ({Hit, Way} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL fifo_hit got h=%b way=%0d exp 1 0", Hit, Way);
        end
        a = dut.age_q[0];
        checks++;
        if (a !== 8'h1B) begin
            errors++; $display("FAIL fifo_hit_age got %h exp 1b", a);
        end
        do_access(3'd0, 4'b1111, 4'b0000, FIFO);
        checks++;
        if ({Way, Evict} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL fifo_victim0 got way=%0d e=%b exp 0 1", Way, Evict);
        end
        do_access(3'd0, 4'b1111, 4'b0000, FIFO);
        checks++;
        if (Way !== 2'd1) begin
            errors++; $display("FAIL fifo_victim1 got %0d exp 1", Way);
        end
    endtask

    task automatic test_random();
        logic [7:0] m;
        logic [7:0] a;
        logic [3:0] mask;
        do_reset();
        m = 8'h01;
        for (int i = 0; i < 20; i++) begin
            do_access(3'd2, 4'b1111, 4'b0000, RND);
            checks++;
            if ({Way, Evict} !== {m[1:0], 1'b1}) begin
                errors++;
                $display("FAIL rand_%0d got way=%0d e=%b exp %0d 1",
                         i, Way, Evict, m[1:0]);
            end
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        end
        a = dut.age_q[2];
        mask = '0;
        for (int w = 0; w < 4; w++) begin
            mask[a[w*2 +: 2]] = 1'b1;
        end
        checks++;
        if (mask !== 4'hF) begin
            errors++; $display("FAIL rand_perm got %h mask %b exp 1111", a, mask);
        end
        a = dut.age_q[5];
        checks++;
        if (a !== 8'hE4) begin
            errors++; $display("FAIL rand_set5 got %h exp e4", a);
        end
    endtask

    task automatic test_multihit();
        do_reset();
        do_access(3'd0, 4'b1111, 4'b0110, LRU);
        checks++;
        if ({Way, Hit, MultiHit, Evict} !== {2'd1, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL multihit got way=%0d h=%b m=%b e=%b exp 1 1 1 0",
                     Way, Hit, MultiHit, Evict);
        end
        do_access(3'd0, 4'b0111, 4'b1000, LRU);
        checks++;
        if ({Way, Hit, MultiHit, Evict} !== {2'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL eq_mask got way=%0d h=%b m=%b e=%b exp 3 0 0 0",
                     Way, Hit, MultiHit, Evict);
        end
    endtask

    task automatic test_flush();
        logic [7:0] a;
        do_reset();
        do_access(3'd1, 4'b0001, 4'b0000, LRU);
        do_access(3'd6, 4'b0011, 4'b0000, LRU);
        @(negedge CLK);
        SetIdx = 3'd1;
        Valid  = 4'b0000;
        Eq     = 4'b0000;
        Access = 1'b1;
        Flush  = 1'b1;
        @(posedge CLK);
        #1;
        Access = 1'b0;
        Flush  = 1'b0;
        checks++;
        if ({Done, Way} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL flush_hold got d=%b way=%0d exp 0 2", Done, Way);
        end
        a = dut.age_q[1];
        checks++;
        if (a !== 8'hE4) begin
            errors++; $display("FAIL flush_age1 got %h exp e4", a);
        end
        a = dut.age_q[6];
        checks++;
        if (a !== 8'hE4) begin
            errors++; $display("FAIL flush_age6 got %h exp e4", a);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        do_reset();
        do_access(3'd4, 4'b0011, 4'b0000, LRU);
        checks++;
        if ({Way, Done} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset got way=%0d d=%b exp 2 1", Way, Done);
        end
        a = dut.age_q[4];
        checks++;
        if (a !== 8'hC9) begin
            errors++; $display("FAIL pre_reset_age got %h exp c9", a);
        end
        ResetN = 1'b0;
        #1;
        checks++;
        if ({Way, Done, Hit, Evict} !== {2'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got way=%0d d=%b h=%b e=%b exp 0 0 0 0",
                     Way, Done, Hit, Evict);
        end
        a = dut.age_q[4];
        checks++;
        if (a !== 8'hE4) begin
            errors++; $display("FAIL mid_reset_age got %h exp e4", a);
        end
        @(negedge CLK);
        ResetN = 1'b1;
    endtask

    initial begin
        ResetN = 1'b0;
        Access = 1'b0;
        Flush  = 1'b0;
        SetIdx = '0;
        Valid  = '0;
        Eq     = '0;
        Policy = LRU;
        test_reset();
        test_first_fill();
        test_lru();
        test_fifo();
        test_random();
        test_multihit();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
